// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/cmp/logic ops, shift-add multiply, valid/ready on both sides.
// Optional registered status flags {zero,carry,borrow,lt} when ALU_FLAGS_EN is defined.
module alu_mc #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [RW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   a_x, b_x;
    logic [RW-1:0]   alu_res;
    logic [RW-1:0]   acc_step;
    logic            a_lt_b;
    logic            accept;
    logic            last_iter;

    assign a_x       = {{WIDTH{1'b0}}, a};
    assign b_x       = {{WIDTH{1'b0}}, b};
    assign a_lt_b    = (a < b);
    assign accept    = (state_q == S_IDLE) && in_valid;
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_iter = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DONE);

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_x + b_x;
            OP_SUB:  alu_res = a_x - b_x;
            OP_CMP:  alu_res = a_lt_b ? RW'(1) : ((a > b) ? RW'(2) : '0);
            OP_AND:  alu_res = a_x & b_x;
            OP_OR:   alu_res = a_x | b_x;
            OP_XOR:  alu_res = a_x ^ b_x;
            OP_MUL:  alu_res = '0;
            default: alu_res = a_x;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = (op == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (last_iter) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic lt_q;
`endif

    // The accept edge performs the first multiply iteration so that the product
    // is ready WIDTH cycles after accept with only WIDTH-1 cycles spent in MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result   <= '0;
`ifdef ALU_FLAGS_EN
            flags    <= '0;
            lt_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                if (op == OP_MUL) begin
                    acc_q    <= b[0] ? a_x : '0;
                    mcand_q  <= a_x << 1;
                    mplier_q <= b >> 1;
                    cnt_q    <= CW'(1);
`ifdef ALU_FLAGS_EN
                    lt_q     <= a_lt_b;
`endif
                end else begin
                    result <= alu_res;
`ifdef ALU_FLAGS_EN
                    flags  <= {(alu_res == '0),
                               (op == OP_ADD) ? alu_res[WIDTH] : 1'b0,
                               (op == OP_SUB) ? a_lt_b : 1'b0,
                               a_lt_b};
`endif
                end
            end
            if (state_q == S_MUL) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
                if (last_iter) begin
                    result <= acc_step;
`ifdef ALU_FLAGS_EN
                    flags  <= {(acc_step == '0), 1'b0, 1'b0, lt_q};
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: WIDTH=4 instance checked every cycle against a transaction model,
// plus a WIDTH=8 instance exercised with directed literal vectors. Flags checked under ALU_FLAGS_EN.
module tb_alu_mc;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy;
    logic [3:0] a = '0, b = '0;
    logic [2:0] op = '0;
    logic [7:0] result;
    logic [3:0] flags;

    logic        v8_in_valid = 1'b0, v8_in_ready, v8_out_valid, v8_out_ready = 1'b1, v8_busy;
    logic [7:0]  v8_a = '0, v8_b = '0;
    logic [2:0]  v8_op = '0;
    logic [15:0] v8_result;
    logic [3:0]  v8_flags;

`ifdef ALU_FLAGS_EN
    alu_mc #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy), .flags(flags));
    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready), .a(v8_a), .b(v8_b),
        .op(v8_op), .out_valid(v8_out_valid), .out_ready(v8_out_ready), .result(v8_result),
        .busy(v8_busy), .flags(v8_flags));
`else
    assign flags    = '0;
    assign v8_flags = '0;
    alu_mc #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy));
    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8_in_valid), .in_ready(v8_in_ready), .a(v8_a), .b(v8_b),
        .op(v8_op), .out_valid(v8_out_valid), .out_ready(v8_out_ready), .result(v8_result),
        .busy(v8_busy));
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rand_or = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on zero-extended operands, masked to 2*w bits.
    function automatic logic [15:0] model_res(input int w, input logic [7:0] x, input logic [7:0] y,
                                              input logic [2:0] o);
        longint unsigned ux, uy, m, r;
        ux = longint'(x);
        uy = longint'(y);
        m  = (longint'(1) << (2 * w)) - 1;
        case (o)
            3'd0: r = ux + uy;
            3'd1: r = ux - uy;
            3'd2: r = ux * uy;
            3'd3: r = (ux < uy) ? 1 : ((ux > uy) ? 2 : 0);
            3'd4: r = ux & uy;
            3'd5: r = ux | uy;
            3'd6: r = ux ^ uy;
            default: r = ux;
        endcase
        return 16'(r & m);
    endfunction

    function automatic logic [3:0] model_flags(input int w, input logic [7:0] x, input logic [7:0] y,
                                               input logic [2:0] o, input logic [15:0] r);
        return {(r == 16'd0), (o == 3'd0) ? r[w] : 1'b0, (o == 3'd1) && (x < y), (x < y)};
    endfunction

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        int         acc_cyc;
        int         lat;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_t;
    logic [15:0] mon_r;

    // Compare process for the WIDTH=4 instance; inputs change only just after posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_result", 32'(result), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
`ifdef ALU_FLAGS_EN
            check("rst_flags", 32'(flags), 32'd0);
`endif
        end else begin
            if (exp_q.size() == 0) begin
                check("idle_in_ready", 32'(in_ready), 32'd1);
                check("idle_out_valid", 32'(out_valid), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
            end else begin
                mon_t = exp_q[0];
                check("busy_in_ready", 32'(in_ready), 32'd0);
                check("busy_busy", 32'(busy), 32'd1);
                if ((cyc - mon_t.acc_cyc) >= (mon_t.lat - 1)) begin
                    check("out_valid_due", 32'(out_valid), 32'd1);
                    check("result", 32'(result), 32'(mon_t.res));
`ifdef ALU_FLAGS_EN
                    check("flags", 32'(flags), 32'(mon_t.flg));
`endif
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    check("out_valid_early", 32'(out_valid), 32'd0);
                end
            end
            if (in_valid && in_ready) begin
                mon_r = model_res(W, 8'(a), 8'(b), op);
                mon_t.res = mon_r[7:0];
                mon_t.flg = model_flags(W, 8'(a), 8'(b), op, mon_r);
                mon_t.acc_cyc = cyc + 1;
                mon_t.lat = (op == 3'd2) ? W : 1;
                exp_q.push_back(mon_t);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one op on the WIDTH=4 port; returns 1 time unit after the accept edge.
    task automatic issue(input logic [3:0] xa, input logic [3:0] xb, input logic [2:0] xo,
                         output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; a = xa; b = xb; op = xo;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        op = 3'($urandom_range(0, 7));
    endtask

    task automatic run_op(input string name, input logic [3:0] xa, input logic [3:0] xb,
                          input logic [2:0] xo, input logic [7:0] exp_res, input int exp_lat,
                          input logic [3:0] exp_flg);
        bit ok;
        int lat;
        issue(xa, xb, xo, ok);
        if (ok) begin
            lat = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                lat++;
                if (out_valid) break;
            end
            check({name, "_valid"}, 32'(out_valid), 32'd1);
            check({name, "_res"}, 32'(result), 32'(exp_res));
            check({name, "_lat"}, 32'(lat), 32'(exp_lat));
`ifdef ALU_FLAGS_EN
            check({name, "_flags"}, 32'(flags), 32'(exp_flg));
`else
            if (exp_flg === 4'hx) check({name, "_flags"}, 32'd0, 32'd1);
`endif
        end
    endtask

    task automatic run8(input string name, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [2:0] xo, input logic [15:0] exp_res, input int exp_lat,
                        input logic [3:0] exp_flg);
        bit ok;
        int lat;
        ok = 1'b0;
        @(posedge clk);
        #1;
        v8_in_valid = 1'b1; v8_a = xa; v8_b = xb; v8_op = xo;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (v8_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        v8_in_valid = 1'b0; v8_a = 8'($urandom_range(0, 255)); v8_b = 8'($urandom_range(0, 255));
        check({name, "_accept"}, 32'(ok), 32'd1);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (v8_out_valid) break;
        end
        check({name, "_res"}, 32'(v8_result), 32'(exp_res));
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
`ifdef ALU_FLAGS_EN
        check({name, "_flags"}, 32'(v8_flags), 32'(exp_flg));
`else
        if (exp_flg === 4'hx) check({name, "_flags"}, 32'd0, 32'd1);
`endif
    endtask

    initial begin
        bit ok;
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        check("post_reset_in_ready8", 32'(v8_in_ready), 32'd1);

        // Reset in the middle of a multiply discards it.
        issue(4'hF, 4'hF, 3'd2, ok);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midmul_rst_valid", 32'(out_valid), 32'd0);
        check("midmul_rst_result", 32'(result), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_abort_valid", 32'(out_valid), 32'd0);
        check("after_abort_ready", 32'(in_ready), 32'd1);
        run_op("add_2_3", 4'h2, 4'h3, 3'd0, 8'h05, 1, 4'b0001);

        run_op("add_f_f", 4'hF, 4'hF, 3'd0, 8'h1E, 1, 4'b0100);
        run_op("sub_3_5", 4'h3, 4'h5, 3'd1, 8'hFE, 1, 4'b0011);
        run_op("mul_f_f", 4'hF, 4'hF, 3'd2, 8'hE1, 4, 4'b0000);
        run_op("mul_0_9", 4'h0, 4'h9, 3'd2, 8'h00, 4, 4'b1001);
        run_op("mul_6_d", 4'h6, 4'hD, 3'd2, 8'h4E, 4, 4'b0001);
        run_op("cmp_3_7", 4'h3, 4'h7, 3'd3, 8'h01, 1, 4'b0001);
        run_op("cmp_7_3", 4'h7, 4'h3, 3'd3, 8'h02, 1, 4'b0000);
        run_op("cmp_5_5", 4'h5, 4'h5, 3'd3, 8'h00, 1, 4'b1000);
        run_op("and_c_a", 4'hC, 4'hA, 3'd4, 8'h08, 1, 4'b0000);
        run_op("or_c_a",  4'hC, 4'hA, 3'd5, 8'h0E, 1, 4'b0000);
        run_op("xor_c_a", 4'hC, 4'hA, 3'd6, 8'h06, 1, 4'b0000);
        run_op("pass_c",  4'hC, 4'h3, 3'd7, 8'h0C, 1, 4'b0000);
        run_op("sub_5_5", 4'h5, 4'h5, 3'd1, 8'h00, 1, 4'b1000);

        // Backpressure: result held, new requests ignored.
        @(posedge clk);
        #1 out_ready = 1'b0;
        run_op("bp_add", 4'h9, 4'h8, 3'd0, 8'h11, 1, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; a = 4'(i); b = 4'hF; op = 3'd6;
            @(negedge clk);
            check("bp_hold_result", 32'(result), 32'h11);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_idle", 32'(in_ready), 32'd1);
        run_op("bp_next", 4'h4, 4'h1, 3'd1, 8'h03, 1, 4'b0000);

        run8("w8_mul_ff_ff", 8'hFF, 8'hFF, 3'd2, 16'hFE01, 8, 4'b0000);
        run8("w8_mul_0_9", 8'h00, 8'h09, 3'd2, 16'h0000, 8, 4'b1001);
        run8("w8_add_ff_ff", 8'hFF, 8'hFF, 3'd0, 16'h01FE, 1, 4'b0100);
        run8("w8_sub_3_5", 8'h03, 8'h05, 3'd1, 16'hFFFE, 1, 4'b0011);

        // Random ops with random consumer stalls, checked by the compare process.
        rand_or = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), ok);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        rand_or = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
